// File: rtl/md_unit.sv
// RV32M multiply/divide unit: fixed-latency multiply, radix-2 restoring divide, result held until writeback.
// Optional build macro MD_EARLY_OUT_EN lets trivial divides skip the 32 iteration steps.
module md_unit #(
    parameter int MUL_LAT   = 3,
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid,
    input  logic [2:0]       issue_func3,
    input  logic [TAG_W-1:0] issue_pd,
    input  logic [4:0]       issue_rob,
    input  logic [31:0]      issue_src1,
    input  logic [31:0]      issue_src2,
    output logic             fu_ready,
    input  logic             mispredict,
    input  logic [4:0]       mispredict_tag,
    input  logic [4:0]       rob_tail,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_pd,
    output logic [4:0]       wb_rob,
    output logic [31:0]      wb_data
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         func3_q, func3_d;
    logic [TAG_W-1:0]   pd_q, pd_d;
    logic [4:0]         rob_q, rob_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        src1_q, src1_d, src2_q, src2_d;
    logic [31:0]        quo_q, quo_d, rem_q, rem_d;
    logic [31:0]        res_q, res_d;

    // Circular membership test for [mispredict_tag+1, rob_tail) modulo ROB_DEPTH.
    function automatic logic inSquash(input logic [4:0] r);
        int start, off, len;
        start = (int'(mispredict_tag) + 1) % ROB_DEPTH;
        off   = (int'(r) + ROB_DEPTH - start) % ROB_DEPTH;
        len   = (int'(rob_tail) + ROB_DEPTH - start) % ROB_DEPTH;
        return off < len;
    endfunction

    logic kill, issueSquashed, accept;
    assign kill          = mispredict && (state_q != IDLE) && inSquash(rob_q);
    assign issueSquashed = mispredict && inSquash(issue_rob);
    assign accept        = issue_valid && (state_q == IDLE) && !issueSquashed;

    logic        aSgn, bSgn, issueDivSgn;
    logic [63:0] a64, b64, prod;
    logic [31:0] mulRes, absSrc1;
    assign aSgn        = (issue_func3[1:0] != 2'b11);
    assign bSgn        = (issue_func3[1:0] == 2'b01);
    assign a64         = {{32{aSgn & issue_src1[31]}}, issue_src1};
    assign b64         = {{32{bSgn & issue_src2[31]}}, issue_src2};
    assign prod        = a64 * b64;
    assign mulRes      = (issue_func3[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    assign issueDivSgn = !issue_func3[0];
    assign absSrc1     = (issueDivSgn && issue_src1[31]) ? -issue_src1 : issue_src1;

    logic        divSgn, divZero, divOvf, early;
    logic [31:0] dvs, qFix, rFix, fixRes;
    logic [32:0] shifted, diff;
    assign divSgn  = !func3_q[0];
    assign dvs     = (divSgn && src2_q[31]) ? -src2_q : src2_q;
    assign divZero = (src2_q == 32'd0);
    assign divOvf  = divSgn && (src1_q == 32'h8000_0000) && (src2_q == 32'hFFFF_FFFF);
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs};
    assign qFix    = (divSgn && (src1_q[31] ^ src2_q[31])) ? -quo_q : quo_q;
    assign rFix    = (divSgn && src1_q[31]) ? -rem_q : rem_q;

    always_comb begin
        fixRes = func3_q[1] ? rFix : qFix;
        if (divZero)     fixRes = func3_q[1] ? src1_q : 32'hFFFF_FFFF;
        else if (divOvf) fixRes = func3_q[1] ? 32'd0 : 32'h8000_0000;
    end

`ifdef MD_EARLY_OUT_EN
    logic [31:0] dvd;
    assign dvd   = (divSgn && src1_q[31]) ? -src1_q : src1_q;
    assign early = divZero || divOvf || (dvs > dvd);
`else
    assign early = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        func3_d = func3_q;
        pd_d    = pd_q;
        rob_d   = rob_q;
        cnt_d   = cnt_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (accept) begin
                func3_d = issue_func3;
                pd_d    = issue_pd;
                rob_d   = issue_rob;
                src1_d  = issue_src1;
                src2_d  = issue_src2;
                if (issue_func3[2]) begin
                    state_d = DIV;
                    cnt_d   = 5'd31;
                    quo_d   = absSrc1;
                    rem_d   = 32'd0;
                end else begin
                    res_d   = mulRes;
                    cnt_d   = 5'(MUL_LAT - 1);
                    state_d = (MUL_LAT == 1) ? DONE : MUL;
                end
            end
            MUL: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q <= 5'd1) state_d = DONE;
            end
            DIV: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd31 && early) begin
                    // Trivial divide: quotient 0, remainder is the dividend magnitude.
                    quo_d   = 32'd0;
                    rem_d   = quo_q;
                    state_d = FIX;
                end else begin
                    if (!diff[32]) begin
                        rem_d = diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = shifted[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    if (cnt_q == 5'd0) state_d = FIX;
                end
            end
            FIX: begin
                res_d   = fixRes;
                state_d = DONE;
            end
            DONE: if (wb_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            func3_q <= 3'd0;
            pd_q    <= '0;
            rob_q   <= 5'd0;
            cnt_q   <= 5'd0;
            src1_q  <= 32'd0;
            src2_q  <= 32'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            res_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            func3_q <= func3_d;
            pd_q    <= pd_d;
            rob_q   <= rob_d;
            cnt_q   <= cnt_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
        end
    end

    assign fu_ready = (state_q == IDLE);
    // A flush of the held op withdraws wb_valid in the same cycle so no handshake can land.
    assign wb_valid = (state_q == DONE) && !kill;
    assign wb_pd    = pd_q;
    assign wb_rob   = rob_q;
    assign wb_data  = res_q;

    issueWhileBusy: assert property (@(posedge clk) disable iff (!reset_n) !(issue_valid && !fu_ready));

endmodule

// File: tb/tb_md_unit.sv
// Directed scoreboard bench for md_unit: multiplies, divides, special cases, stall, squash and reset.
module tb_md_unit;

    logic        clk;
    logic        reset_n;
    logic        issue_valid;
    logic [2:0]  issue_func3;
    logic [6:0]  issue_pd;
    logic [4:0]  issue_rob;
    logic [31:0] issue_src1;
    logic [31:0] issue_src2;
    logic        fu_ready;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    logic [4:0]  rob_tail;
    logic        wb_valid;
    logic        wb_ready;
    logic [6:0]  wb_pd;
    logic [4:0]  wb_rob;
    logic [31:0] wb_data;

    md_unit #(.MUL_LAT(3), .ROB_DEPTH(16), .TAG_W(7)) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_func3(issue_func3), .issue_pd(issue_pd),
        .issue_rob(issue_rob), .issue_src1(issue_src1), .issue_src2(issue_src2),
        .fu_ready(fu_ready),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag), .rob_tail(rob_tail),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_pd(wb_pd), .wb_rob(wb_rob), .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  pd;
        logic [4:0]  rob;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

`ifdef MD_EARLY_OUT_EN
    localparam int EARLY_LAT = 3;
`else
    localparam int EARLY_LAT = 34;
`endif
    localparam int FULL_LAT = 34;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Drives one issue at a negedge; returns at the first negedge after the accept edge (cycle 1).
    task automatic applyStimulus(input logic [2:0] f3, input logic [6:0] pd, input logic [4:0] rob,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit push, input logic [31:0] expData, input int lat);
        exp_t e;
        if (push) begin
            e.pd = pd; e.rob = rob; e.data = expData; e.lat = lat;
            sbq.push_back(e);
        end
        issue_valid = 1'b1;
        issue_func3 = f3;
        issue_pd    = pd;
        issue_rob   = rob;
        issue_src1  = a;
        issue_src2  = b;
        cyc = 0;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic collectResult(input string tag, input int stall);
        exp_t e;
        while (!wb_valid && cyc < 200) tick();
        checkOutput({tag, ".valid"}, {31'd0, wb_valid}, 32'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput({tag, ".latency"}, 32'(cyc), 32'(e.lat));
            checkOutput({tag, ".data"}, wb_data, e.data);
            checkOutput({tag, ".pd"}, {25'd0, wb_pd}, {25'd0, e.pd});
            checkOutput({tag, ".rob"}, {27'd0, wb_rob}, {27'd0, e.rob});
            for (int i = 0; i < stall; i++) begin
                tick();
                checkOutput({tag, ".stallValid"}, {31'd0, wb_valid}, 32'd1);
                checkOutput({tag, ".stallData"}, wb_data, e.data);
                checkOutput({tag, ".stallReady"}, {31'd0, fu_ready}, 32'd0);
            end
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        checkOutput({tag, ".readyAfter"}, {31'd0, fu_ready}, 32'd1);
        checkOutput({tag, ".validAfter"}, {31'd0, wb_valid}, 32'd0);
    endtask

    task automatic pulseMispredict(input logic [4:0] tag, input logic [4:0] tail);
        mispredict     = 1'b1;
        mispredict_tag = tag;
        rob_tail       = tail;
        tick();
        mispredict     = 1'b0;
    endtask

    task automatic expectNoWb(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (wb_valid) seen++;
        end
        checkOutput(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; issue_valid = 1'b0; issue_func3 = 3'd0; issue_pd = 7'd0;
        issue_rob = 5'd0; issue_src1 = 32'd0; issue_src2 = 32'd0;
        mispredict = 1'b0; mispredict_tag = 5'd0; rob_tail = 5'd0; wb_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        tick();
        checkOutput("reset.fu_ready", {31'd0, fu_ready}, 32'd1);
        checkOutput("reset.wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("reset.wb_data", wb_data, 32'd0);
        checkOutput("reset.wb_pd", {25'd0, wb_pd}, 32'd0);
        checkOutput("reset.wb_rob", {27'd0, wb_rob}, 32'd0);

        // Multiplies
        applyStimulus(3'b000, 7'h15, 5'd3, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 3);
        collectResult("mul", 0);
        applyStimulus(3'b011, 7'h16, 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 3);
        collectResult("mulhu", 0);
        applyStimulus(3'b010, 7'h17, 5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 3);
        collectResult("mulhsu", 0);
        applyStimulus(3'b001, 7'h18, 5'd6, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 3);
        collectResult("mulh", 0);

        // Divides and special cases
        applyStimulus(3'b100, 7'h20, 5'd7, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, FULL_LAT);
        collectResult("div", 0);
        applyStimulus(3'b110, 7'h21, 5'd8, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, FULL_LAT);
        collectResult("rem", 0);
        applyStimulus(3'b101, 7'h22, 5'd9, 32'h0000_1234, 32'd0, 1, 32'hFFFF_FFFF, EARLY_LAT);
        collectResult("divuZero", 0);
        applyStimulus(3'b110, 7'h23, 5'd10, 32'd5, 32'd0, 1, 32'd5, EARLY_LAT);
        collectResult("remZero", 0);
        applyStimulus(3'b100, 7'h24, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, EARLY_LAT);
        collectResult("divOvf", 0);
        applyStimulus(3'b111, 7'h25, 5'd12, 32'd100, 32'd7, 1, 32'd2, FULL_LAT);
        collectResult("remu", 0);
        applyStimulus(3'b100, 7'h26, 5'd13, 32'd3, 32'd10, 1, 32'd0, EARLY_LAT);
        collectResult("divSmall", 0);
        applyStimulus(3'b110, 7'h27, 5'd14, 32'hFFFF_FFFD, 32'd10, 1, 32'hFFFF_FFFD, EARLY_LAT);
        collectResult("remSmall", 0);

        // Writeback back-pressure
        applyStimulus(3'b000, 7'h30, 5'd1, 32'd1000, 32'd1000, 1, 32'd1000000, 3);
        collectResult("stall", 5);

        // Squash of an in-flight divide
        applyStimulus(3'b100, 7'h40, 5'd6, 32'd50, 32'd3, 0, 32'd0, 0);
        while (cyc < 5) tick();
        pulseMispredict(5'd4, 5'd9);
        checkOutput("squash.fu_ready", {31'd0, fu_ready}, 32'd1);
        checkOutput("squash.wb_valid", {31'd0, wb_valid}, 32'd0);
        expectNoWb("squash.noWb", 40);

        applyStimulus(3'b100, 7'h41, 5'd3, 32'd50, 32'd3, 1, 32'd16, FULL_LAT);
        while (cyc < 5) tick();
        pulseMispredict(5'd4, 5'd9);
        collectResult("survive", 0);

        applyStimulus(3'b100, 7'h42, 5'd0, 32'd50, 32'd3, 0, 32'd0, 0);
        while (cyc < 5) tick();
        pulseMispredict(5'd14, 5'd2);
        checkOutput("wrap.fu_ready", {31'd0, fu_ready}, 32'd1);
        expectNoWb("wrap.noWb", 40);

        applyStimulus(3'b101, 7'h43, 5'd5, 32'd100, 32'd7, 1, 32'd14, FULL_LAT);
        while (cyc < 5) tick();
        pulseMispredict(5'd4, 5'd5);
        collectResult("emptyRange", 0);

        // Issue coinciding with a flush
        mispredict = 1'b1; mispredict_tag = 5'd4; rob_tail = 5'd9;
        applyStimulus(3'b000, 7'h50, 5'd7, 32'd2, 32'd3, 0, 32'd0, 0);
        mispredict = 1'b0;
        checkOutput("issueSquashed.fu_ready", {31'd0, fu_ready}, 32'd1);
        expectNoWb("issueSquashed.noWb", 10);

        mispredict = 1'b1; mispredict_tag = 5'd4; rob_tail = 5'd9;
        applyStimulus(3'b000, 7'h51, 5'd2, 32'd2, 32'd3, 1, 32'd6, 3);
        mispredict = 1'b0;
        checkOutput("issueKept.fu_ready", {31'd0, fu_ready}, 32'd0);
        collectResult("issueKept", 0);

        // Flush arriving together with the writeback handshake
        applyStimulus(3'b000, 7'h60, 5'd10, 32'd4, 32'd4, 0, 32'd0, 0);
        while (!wb_valid && cyc < 20) tick();
        mispredict = 1'b1; mispredict_tag = 5'd8; rob_tail = 5'd12; wb_ready = 1'b1;
        #1;
        checkOutput("flushDone.wb_valid", {31'd0, wb_valid}, 32'd0);
        tick();
        mispredict = 1'b0; wb_ready = 1'b0;
        checkOutput("flushDone.fu_ready", {31'd0, fu_ready}, 32'd1);
        expectNoWb("flushDone.noWb", 5);

        // Asynchronous reset mid-divide
        applyStimulus(3'b100, 7'h70, 5'd2, 32'd999, 32'd7, 0, 32'd0, 0);
        while (cyc < 10) tick();
        reset_n = 1'b0;
        #1;
        checkOutput("midReset.fu_ready", {31'd0, fu_ready}, 32'd1);
        checkOutput("midReset.wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("midReset.wb_data", wb_data, 32'd0);
        tick();
        reset_n = 1'b1;
        expectNoWb("midReset.noWb", 40);

        checkOutput("scoreboardEmpty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- RV32M multiply/divide functional unit, directly downstream of the MD-class reservation station.
- Accepts one issued op per transaction, with operands already read from the PRF.
- Multiplies complete in a fixed pipelined latency; divides and remainders use an iterative radix-2 FSM.
- Holds the result until the writeback/CDB arbiter accepts it. Squashes in-flight work on a ROB mispredict.

Parameters:
- MUL_LAT, 3, cycles from accept edge to wb_valid for MUL/MULH/MULHSU/MULHU (legal range 1..8)
- ROB_DEPTH, 16, ROB entries; rob indices wrap modulo ROB_DEPTH
- TAG_W, 7, physical register tag width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  RS presents an op (RS fu_issued)
- issue_func3  in  3  M-extension func3 (000 MUL … 111 REMU)
- issue_pd  in  TAG_W  destination preg
- issue_rob  in  5  ROB index of op
- issue_src1  in  32  rs1 value
- issue_src2  in  32  rs2 value
- fu_ready  out  1  unit idle; RS may issue
- mispredict  in  1  ROB flush pulse
- mispredict_tag  in  5  ROB index of mispredicted branch
- rob_tail  in  5  ROB allocation pointer (exclusive end of squash range)
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts result
- wb_pd  out  TAG_W  destination preg
- wb_rob  out  5  ROB index
- wb_data  out  32  result

Behaviour:
- Reset (async, reset_n low): state IDLE, fu_ready=1, wb_valid=0, wb_pd/wb_rob/wb_data=0, counters=0. Asserting reset_n low mid-operation abandons the op immediately; no writeback follows.
- States: IDLE, MUL, DIV, FIX, DONE.
- fu_ready = (state==IDLE), combinational from registered state.
- Accept: issue_valid && fu_ready && !squash(issue_rob) at a rising edge. Latch func3, pd, rob, operands.
  - func3[2]==0 → MUL, counter=MUL_LAT-1.
  - func3[2]==1 → DIV, counter=31.
  - MUL_LAT==1 → DONE directly.
- issue_valid while !fu_ready: ignored. The RS must not do this; flag with an assertion.
- MUL: product is 64-bit with signedness per func3 (MULHSU: rs1 signed, rs2 unsigned). MUL returns [31:0]; others return [63:32]. Decrement counter; at 0 → DONE. wb_valid first high MUL_LAT cycles after the accept edge.
- DIV: restoring radix-2 on magnitudes (signed ops take abs values). One quotient bit per cycle for 32 cycles, then FIX.
- FIX: apply signs. Quotient is negated if operand signs differ; remainder takes the dividend's sign. Then → DONE. wb_valid first high 34 cycles after the accept edge.
- Special cases, resolved in FIX:
  - Divide by zero: quotient=32'hFFFF_FFFF, remainder=dividend.
  - Signed overflow (0x8000_0000 / -1): quotient=0x8000_0000, remainder=0.
- DONE: wb_valid=1. Outputs stable while wb_valid && !wb_ready. On wb_valid && wb_ready → IDLE, so fu_ready is high the next cycle.
- squash(r): true iff r lies in the circular range [mispredict_tag+1, rob_tail) modulo ROB_DEPTH. The range is empty when mispredict_tag+1 == rob_tail (mod).
- mispredict pulse:
  - If an op is held (any non-IDLE state) and squash(held rob) is true → IDLE next cycle, wb_valid=0. A handshake in the same cycle is voided (flush wins).
  - If not squashed, the op continues undisturbed.
  - An issue in the same cycle is accepted only if its own rob is not squashed.
- No back-to-back overlap: a single op is in flight at a time.

Optional Feature:
- Macro MD_EARLY_OUT_EN.
- Defined: DIV state exits to FIX after one cycle when any of these holds:
  - divisor==0;
  - signed overflow;
  - |divisor| > |dividend| (quotient 0, remainder = dividend).

  wb_valid is then high 3 cycles after accept. Results are identical to the full algorithm.
- Undefined: every divide takes the full 34-cycle latency.

Test Plan:
- MUL, src1=7, src2=-3, MUL_LAT=3 → wb_valid on the 3rd cycle after accept, wb_data=0xFFFF_FFEB, wb_pd/wb_rob equal the issued values.
- MULHU 0xFFFF_FFFF×0xFFFF_FFFF → wb_data=0xFFFF_FFFE; MULHSU -1×0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV -7/2 → quotient 0xFFFF_FFFD at cycle 34; REM -7/2 → 0xFFFF_FFFF; DIVU x/0 → 0xFFFF_FFFF; REM 5/0 → 5; DIV 0x8000_0000/-1 → 0x8000_0000.
- wb_ready held low 5 cycles in DONE → wb_valid and data stable; fu_ready stays 0; fu_ready=1 the cycle after the handshake.
- DIV with rob=6 in flight, mispredict_tag=4, rob_tail=9 → IDLE next cycle, no wb. Repeat with rob=3 → completes normally. Wrap case: tag=14, tail=2, rob=0 → squashed.
- reset_n low at DIV cycle 10 → fu_ready=1, wb_valid=0 immediately. With MD_EARLY_OUT_EN, DIV 3/10 → quotient 0 at cycle 3.
